// File: rtl/tape_dev_pkg.sv
// -----------------------------------------------------------------------------
// tape_dev_pkg
// Shared constants and types for the PC11-style tape register controller:
// bus/field widths, register indices, PRS/PPS bit positions, request-owner
// and arbiter-state encodings, and the engine request bundle.
// -----------------------------------------------------------------------------
package tape_dev_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ERR_W  = 4;

    // Register select (octal bus addresses 177550..177556)
    localparam logic [ADDR_W-1:0] REG_PRS = 2'd0;
    localparam logic [ADDR_W-1:0] REG_PRB = 2'd1;
    localparam logic [ADDR_W-1:0] REG_PPS = 2'd2;
    localparam logic [ADDR_W-1:0] REG_PPB = 2'd3;

    // Status register bit positions
    localparam int unsigned CSR_GO    = 0;   // PRS GO / PPS FLUSH (write-only)
    localparam int unsigned CSR_IE    = 6;
    localparam int unsigned CSR_DONE  = 7;   // PRS DONE / PPS READY
    localparam int unsigned PRS_BUSY  = 11;
    localparam int unsigned CSR_ERR   = 15;

    // Which function currently owns the engine
    typedef enum logic [1:0] {
        OWN_RD = 2'd0,
        OWN_PU = 2'd1,
        OWN_FL = 2'd2
    } owner_e;

    // Arbiter states
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t A_IDLE = 2'd0;
    localparam arb_state_t A_REQ  = 2'd1;
    localparam arb_state_t A_BUSY = 2'd2;

    // Level requests presented to the tape engine
    typedef struct packed {
        logic rd;
        logic pu;
        logic fl;
        logic clr;
    } tape_req_t;

    // Engine acknowledge: reads answer with busy, punch/flush drop ready
    function automatic logic req_acked(owner_e own, logic read_busy, logic punch_ready);
        return (own == OWN_RD) ? read_busy : !punch_ready;
    endfunction

endpackage

// File: rtl/tape_flush_timer.sv
// -----------------------------------------------------------------------------
// tape_flush_timer
// Punch-idle timer used for automatic flush of a partial punch block
// (instantiated only when TAPE_AUTOFLUSH_EN is defined).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : count this cycle (engine idle, nothing pending)
//   clr_i         : restart from zero (no dirty data or punch/flush activity)
//   expire_o      : one-cycle registered pulse after CYCLES enabled cycles
// -----------------------------------------------------------------------------
module tape_flush_timer #(
    parameter int unsigned CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    // Count saturates at CYCLES so expiry fires only once per idle period
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q != CNT_W'(CYCLES)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            expire_d = (cnt_q == CNT_W'(CYCLES - 1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/tape_dev_ctrl.sv
// -----------------------------------------------------------------------------
// tape_dev_ctrl
// PC11-style paper tape reader/punch register block (PRS/PRB/PPS/PPB) that
// queues read, punch and flush work and sequences the shared SD tape engine
// one request at a time. Optional automatic flush of a partial punch block
// after an idle timeout when TAPE_AUTOFLUSH_EN is defined.
// Ports:
//   i_clk, i_reset_n            : clock, async active-low reset
//   i_bus_wr/i_bus_rd           : one-cycle register write/read strobes
//   i_bus_addr, i_bus_wdata     : register select and write data
//   o_bus_rdata                 : combinational read data
//   o_tape_read/punch/flush     : registered level requests to the engine
//   o_tape_clear_done           : registered one-cycle done-clear pulse
//   o_tape_punch_data           : latched PPB byte
//   i_tape_read_busy/done       : engine reader status
//   i_tape_punch_ready          : engine idle / ready for punch
//   i_tape_read_data            : engine read byte
//   i_sd_error                  : engine error code, nonzero = failed
//   o_irq_pr, o_irq_pp          : level interrupt requests
// -----------------------------------------------------------------------------
module tape_dev_ctrl
    import tape_dev_pkg::*;
#(
    parameter int unsigned SYS_FRQ  = 27_000_000,
    parameter int unsigned FLUSH_MS = 1000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_bus_wr,
    input  logic              i_bus_rd,
    input  logic [1:0]        i_bus_addr,
    input  logic [15:0]       i_bus_wdata,
    output logic [15:0]       o_bus_rdata,
    output logic              o_tape_read,
    output logic              o_tape_punch,
    output logic              o_tape_flush,
    output logic              o_tape_clear_done,
    output logic [7:0]        o_tape_punch_data,
    input  logic              i_tape_read_busy,
    input  logic              i_tape_read_done,
    input  logic              i_tape_punch_ready,
    input  logic [7:0]        i_tape_read_data,
    input  logic [3:0]        i_sd_error,
    output logic              o_irq_pr,
    output logic              o_irq_pp
);

    logic              pr_ie_q, pr_ie_d;
    logic              pp_ie_q, pp_ie_d;
    logic              read_pend_q, read_pend_d;
    logic              punch_pend_q, punch_pend_d;
    logic              flush_pend_q, flush_pend_d;
    logic              clr_pend_q, clr_pend_d;
    arb_state_t        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [BYTE_W-1:0] punch_data_q, punch_data_d;
    tape_req_t         req_q, req_d;

    logic err_c;
    logic rd_owned_c;
    logic pp_owned_c;
    logic prs_busy_c;
    logic pps_ready_c;
    logic wr_prs_c, wr_pps_c, wr_ppb_c, rd_prb_c;
    logic go_c;
    logic flush_expire_c;

    // Status derived from queue and ownership
    assign err_c       = (i_sd_error != '0);
    assign rd_owned_c  = (state_q != A_IDLE) && (owner_q == OWN_RD);
    assign pp_owned_c  = (state_q != A_IDLE) && (owner_q != OWN_RD);
    assign prs_busy_c  = read_pend_q || rd_owned_c;
    assign pps_ready_c = !(punch_pend_q || flush_pend_q || pp_owned_c) && i_tape_punch_ready;

    // Bus strobe decode
    assign wr_prs_c = i_bus_wr && (i_bus_addr == REG_PRS);
    assign wr_pps_c = i_bus_wr && (i_bus_addr == REG_PPS);
    assign wr_ppb_c = i_bus_wr && (i_bus_addr == REG_PPB);
    assign rd_prb_c = i_bus_rd && (i_bus_addr == REG_PRB);
    assign go_c     = wr_prs_c && i_bus_wdata[CSR_GO] && !err_c && !prs_busy_c;

`ifdef TAPE_AUTOFLUSH_EN
    localparam int unsigned FLUSH_CYCLES = (SYS_FRQ / 1000) * FLUSH_MS;

    logic dirty_q, dirty_d;
    logic timer_en_c, timer_clr_c;

    // Idle timer runs only while unflushed punch data sits in the engine
    assign timer_en_c  = (state_q == A_IDLE) &&
                         !(read_pend_q || punch_pend_q || flush_pend_q || clr_pend_q);
    assign timer_clr_c = !dirty_q || punch_pend_q || flush_pend_q || pp_owned_c;

    tape_flush_timer #(
        .CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk_i    (i_clk),
        .rst_ni   (i_reset_n),
        .en_i     (timer_en_c),
        .clr_i    (timer_clr_c),
        .expire_o (flush_expire_c)
    );
`else
    localparam int unsigned CFG_UNUSED = SYS_FRQ ^ FLUSH_MS;
    assign flush_expire_c = 1'b0;
`endif

    // Next-state: arbiter first, then bus/timer sets so a same-cycle set wins
    always_comb begin
        pr_ie_d      = pr_ie_q;
        pp_ie_d      = pp_ie_q;
        read_pend_d  = read_pend_q;
        punch_pend_d = punch_pend_q;
        flush_pend_d = flush_pend_q;
        clr_pend_d   = clr_pend_q;
        state_d      = state_q;
        owner_d      = owner_q;
        punch_data_d = punch_data_q;
        req_d        = '0;
`ifdef TAPE_AUTOFLUSH_EN
        dirty_d      = dirty_q;
`endif

        case (state_q)
            A_IDLE: begin
                if (clr_pend_q && !i_tape_read_busy) begin
                    req_d.clr  = 1'b1;
                    clr_pend_d = 1'b0;
                end else if (!err_c) begin
                    if (read_pend_q) begin
                        owner_d     = OWN_RD;
                        read_pend_d = 1'b0;
                        state_d     = A_REQ;
                    end else if (punch_pend_q) begin
                        owner_d      = OWN_PU;
                        punch_pend_d = 1'b0;
                        state_d      = A_REQ;
                    end else if (flush_pend_q) begin
                        owner_d      = OWN_FL;
                        flush_pend_d = 1'b0;
                        state_d      = A_REQ;
`ifdef TAPE_AUTOFLUSH_EN
                        dirty_d      = 1'b0;
`endif
                    end
                end
            end
            A_REQ: begin
                if (req_acked(owner_q, i_tape_read_busy, i_tape_punch_ready)) begin
                    state_d = A_BUSY;
                end
            end
            A_BUSY: begin
                if (i_tape_punch_ready) begin
                    state_d = A_IDLE;
`ifdef TAPE_AUTOFLUSH_EN
                    if (owner_q == OWN_PU) begin
                        dirty_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = A_IDLE;
            end
        endcase

        // Request levels follow the registered state so they assert on the grant edge
        req_d.rd = (state_d == A_REQ) && (owner_d == OWN_RD);
        req_d.pu = (state_d == A_REQ) && (owner_d == OWN_PU);
        req_d.fl = (state_d == A_REQ) && (owner_d == OWN_FL);

        if (wr_prs_c) begin
            pr_ie_d = i_bus_wdata[CSR_IE];
        end
        if (go_c) begin
            read_pend_d = 1'b1;
            clr_pend_d  = 1'b1;
        end
        if (rd_prb_c) begin
            clr_pend_d = 1'b1;
        end
        if (wr_pps_c) begin
            pp_ie_d = i_bus_wdata[CSR_IE];
            if (i_bus_wdata[CSR_GO]) begin
                flush_pend_d = 1'b1;
            end
        end
        if (wr_ppb_c && pps_ready_c) begin
            punch_data_d = i_bus_wdata[BYTE_W-1:0];
            punch_pend_d = 1'b1;
        end
        if (flush_expire_c) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pr_ie_q      <= 1'b0;
            pp_ie_q      <= 1'b0;
            read_pend_q  <= 1'b0;
            punch_pend_q <= 1'b0;
            flush_pend_q <= 1'b0;
            clr_pend_q   <= 1'b0;
            state_q      <= A_IDLE;
            owner_q      <= OWN_RD;
            punch_data_q <= '0;
            req_q        <= '0;
`ifdef TAPE_AUTOFLUSH_EN
            dirty_q      <= 1'b0;
`endif
        end else begin
            pr_ie_q      <= pr_ie_d;
            pp_ie_q      <= pp_ie_d;
            read_pend_q  <= read_pend_d;
            punch_pend_q <= punch_pend_d;
            flush_pend_q <= flush_pend_d;
            clr_pend_q   <= clr_pend_d;
            state_q      <= state_d;
            owner_q      <= owner_d;
            punch_data_q <= punch_data_d;
            req_q        <= req_d;
`ifdef TAPE_AUTOFLUSH_EN
            dirty_q      <= dirty_d;
`endif
        end
    end

    // Register read mux
    always_comb begin
        o_bus_rdata = '0;
        case (i_bus_addr)
            REG_PRS: begin
                o_bus_rdata[CSR_IE]   = pr_ie_q;
                o_bus_rdata[CSR_DONE] = i_tape_read_done;
                o_bus_rdata[PRS_BUSY] = prs_busy_c;
                o_bus_rdata[CSR_ERR]  = err_c;
            end
            REG_PRB: begin
                o_bus_rdata = {8'h00, i_tape_read_data};
            end
            REG_PPS: begin
                o_bus_rdata[CSR_IE]   = pp_ie_q;
                o_bus_rdata[CSR_DONE] = pps_ready_c;
                o_bus_rdata[CSR_ERR]  = err_c;
            end
            default: begin
                o_bus_rdata = '0;
            end
        endcase
    end

    assign o_tape_read       = req_q.rd;
    assign o_tape_punch      = req_q.pu;
    assign o_tape_flush      = req_q.fl;
    assign o_tape_clear_done = req_q.clr;
    assign o_tape_punch_data = punch_data_q;

    // Level interrupts track the live flags so raising IE fires immediately
    assign o_irq_pr = pr_ie_q && i_tape_read_done;
    assign o_irq_pp = pp_ie_q && pps_ready_c;

    logic unused_c;
    assign unused_c = &{1'b0, i_bus_wdata[15:8]};

endmodule

// File: tb/tb_tape_dev_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tape_dev_ctrl
// Directed self-checking bench for tape_dev_ctrl. The tape engine is played
// by hand from the stimulus sequence. Honors TAPE_AUTOFLUSH_EN when defined
// (SYS_FRQ=1000, FLUSH_MS=10 gives a 10-cycle flush timeout).
// -----------------------------------------------------------------------------
module tb_tape_dev_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_wr, bus_rd;
    logic [1:0]  bus_addr;
    logic [15:0] bus_wdata, bus_rdata;
    logic        tape_read, tape_punch, tape_flush, tape_clr;
    logic [7:0]  punch_data;
    logic        rd_busy, rd_done, pu_ready;
    logic [7:0]  rd_data;
    logic [3:0]  sd_err;
    logic        irq_pr, irq_pp;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    tape_dev_ctrl #(
        .SYS_FRQ  (1000),
        .FLUSH_MS (10)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_bus_wr           (bus_wr),
        .i_bus_rd           (bus_rd),
        .i_bus_addr         (bus_addr),
        .i_bus_wdata        (bus_wdata),
        .o_bus_rdata        (bus_rdata),
        .o_tape_read        (tape_read),
        .o_tape_punch       (tape_punch),
        .o_tape_flush       (tape_flush),
        .o_tape_clear_done  (tape_clr),
        .o_tape_punch_data  (punch_data),
        .i_tape_read_busy   (rd_busy),
        .i_tape_read_done   (rd_done),
        .i_tape_punch_ready (pu_ready),
        .i_tape_read_data   (rd_data),
        .i_sd_error         (sd_err),
        .o_irq_pr           (irq_pr),
        .o_irq_pp           (irq_pp)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit past the edge and check request exclusivity
    task automatic step();
        @(posedge clk);
        #1;
        chk1("req_exclusive", ($countones({tape_read, tape_punch, tape_flush, tape_clr}) <= 1), 1'b1);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus_wr    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        step();
        bus_wr    = 1'b0;
        bus_wdata = 16'h0000;
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [15:0] exp);
        bus_addr = a;
        #1;
        chk(tag, bus_rdata, exp);
    endtask

    // Called right after the edge where a punch returned the arbiter to idle
    task automatic after_punch();
`ifdef TAPE_AUTOFLUSH_EN
        repeat (11) step();
        chk1("af_not_yet", tape_flush, 1'b0);
        step();
        chk1("af_flush", tape_flush, 1'b1);
        pu_ready = 1'b0;
        step();
        chk1("af_flush_ack", tape_flush, 1'b0);
        pu_ready = 1'b1;
        step();
        repeat (15) step();
        chk1("af_no_reflush", tape_flush, 1'b0);
        chk1("af_no_punch", tape_punch, 1'b0);
`else
        repeat (14) step();
        chk1("no_auto_flush", tape_flush, 1'b0);
        chk1("no_extra_punch", tape_punch, 1'b0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_addr  = 2'd0;
        bus_wdata = 16'h0000;
        rd_busy   = 1'b0;
        rd_done   = 1'b0;
        pu_ready  = 1'b1;
        rd_data   = 8'h00;
        sd_err    = 4'd0;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {5'd0, tape_read, tape_punch, tape_flush, tape_clr, irq_pr, irq_pp, 5'd0}, 16'h0000);
        chk("rst_punch_data", {8'h00, punch_data}, 16'h0000);
        peek("rst_prs", 2'd0, 16'h0000);
        peek("rst_pps", 2'd2, 16'h0080);
        rst_n = 1'b1;
        step();

        // ---- reader: GO+IE, clear pulse, request until busy, done, PRB read
        bus_write(2'd0, 16'h0041);
        chk1("t1_read_not_yet", tape_read, 1'b0);
        peek("t1_prs_pending", 2'd0, 16'h0840);
        chk1("t1_irq_pr_low", irq_pr, 1'b0);
        step();
        chk1("t1_clear_pulse", tape_clr, 1'b1);
        chk1("t1_read_after_clr", tape_read, 1'b0);
        step();
        chk1("t1_clear_end", tape_clr, 1'b0);
        chk1("t1_read_req", tape_read, 1'b1);
        peek("t1_prs_owned", 2'd0, 16'h0840);
        repeat (4) step();
        chk1("t1_read_held", tape_read, 1'b1);
        rd_busy  = 1'b1;
        pu_ready = 1'b0;
        step();
        chk1("t1_read_acked", tape_read, 1'b0);
        step();
        step();
        rd_busy  = 1'b0;
        rd_done  = 1'b1;
        rd_data  = 8'hA5;
        pu_ready = 1'b1;
        peek("t1_prs_done_busy", 2'd0, 16'h08C0);
        step();
        peek("t1_prs_done", 2'd0, 16'h00C0);
        chk1("t1_irq_pr", irq_pr, 1'b1);
        bus_rd   = 1'b1;
        bus_addr = 2'd1;
        #1;
        chk("t1_prb", bus_rdata, 16'h00A5);
        step();
        bus_rd = 1'b0;
        chk1("t1_no_clr_yet", tape_clr, 1'b0);
        step();
        chk1("t1_prb_clear", tape_clr, 1'b1);
        rd_done = 1'b0;
        step();
        chk1("t1_prb_clear_end", tape_clr, 1'b0);
        chk1("t1_irq_pr_drop", irq_pr, 1'b0);
        peek("t1_prs_idle", 2'd0, 16'h0040);

        // ---- punch: back-to-back PPB writes, second ignored
        bus_wr    = 1'b1;
        bus_addr  = 2'd3;
        bus_wdata = 16'h0055;
        step();
        step();
        bus_wr    = 1'b0;
        bus_wdata = 16'h0000;
        chk1("t2_punch_req", tape_punch, 1'b1);
        chk("t2_punch_data", {8'h00, punch_data}, 16'h0055);
        peek("t2_pps_notready", 2'd2, 16'h0000);
        bus_write(2'd3, 16'h00AA);
        chk("t2_ignored_data", {8'h00, punch_data}, 16'h0055);
        chk1("t2_punch_held", tape_punch, 1'b1);
        pu_ready = 1'b0;
        step();
        chk1("t2_punch_acked", tape_punch, 1'b0);
        pu_ready = 1'b1;
        step();
        peek("t2_pps_ready", 2'd2, 16'h0080);
        after_punch();

        // ---- priority: read, then punch, then flush
        bus_write(2'd0, 16'h0001);
        bus_write(2'd3, 16'h0012);
        chk1("t3_clear_pulse", tape_clr, 1'b1);
        bus_write(2'd2, 16'h0001);
        chk("t3_first_grant", {13'd0, tape_read, tape_punch, tape_flush}, 16'h0004);
        peek("t3_pps", 2'd2, 16'h0000);
        peek("t3_prs", 2'd0, 16'h0800);
        rd_busy  = 1'b1;
        pu_ready = 1'b0;
        step();
        chk1("t3_read_acked", tape_read, 1'b0);
        rd_busy  = 1'b0;
        pu_ready = 1'b1;
        step();
        chk1("t3_punch_not_yet", tape_punch, 1'b0);
        step();
        chk("t3_second_grant", {13'd0, tape_read, tape_punch, tape_flush}, 16'h0002);
        chk("t3_punch_data", {8'h00, punch_data}, 16'h0012);
        pu_ready = 1'b0;
        step();
        pu_ready = 1'b1;
        step();
        chk1("t3_flush_not_yet", tape_flush, 1'b0);
        step();
        chk("t3_third_grant", {13'd0, tape_read, tape_punch, tape_flush}, 16'h0001);
        pu_ready = 1'b0;
        step();
        pu_ready = 1'b1;
        step();
        chk1("t3_flush_done", tape_flush, 1'b0);

        // ---- engine error: GO ignored, pending punch held until error clears
        sd_err = 4'd4;
        bus_write(2'd0, 16'h0000);
        peek("t4_prs_err", 2'd0, 16'h8000);
        peek("t4_pps_err", 2'd2, 16'h8080);
        bus_write(2'd0, 16'h0001);
        peek("t4_go_ignored", 2'd0, 16'h8000);
        step();
        step();
        chk("t4_no_request", {12'd0, tape_read, tape_punch, tape_flush, tape_clr}, 16'h0000);
        bus_write(2'd3, 16'h0077);
        peek("t4_pps_pend", 2'd2, 16'h8000);
        step();
        step();
        chk1("t4_punch_held", tape_punch, 1'b0);
        chk("t4_punch_data", {8'h00, punch_data}, 16'h0077);
        sd_err = 4'd0;
        step();
        chk1("t4_punch_released", tape_punch, 1'b1);
        peek("t4_go_not_queued", 2'd0, 16'h0000);
        pu_ready = 1'b0;
        step();
        pu_ready = 1'b1;
        step();
        after_punch();

        // ---- level IRQ on IE set, then reset during A_REQ
        bus_write(2'd0, 16'h0040);
        bus_write(2'd2, 16'h0040);
        chk1("t6_irq_pp_ie", irq_pp, 1'b1);
        chk1("t6_irq_pr_low", irq_pr, 1'b0);
        bus_write(2'd3, 16'h0099);
        chk1("t6_irq_pp_drop", irq_pp, 1'b0);
        step();
        chk1("t6_punch_req", tape_punch, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", {5'd0, tape_read, tape_punch, tape_flush, tape_clr, irq_pr, irq_pp, 5'd0}, 16'h0000);
        chk("t6_rst_punch_data", {8'h00, punch_data}, 16'h0000);
        peek("t6_rst_prs", 2'd0, 16'h0000);
        peek("t6_rst_pps", 2'd2, 16'h0080);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("t6_idle_after", {12'd0, tape_read, tape_punch, tape_flush, tape_clr}, 16'h0000);
        chk1("t6_irq_pp_ie_cleared", irq_pp, 1'b0);
        peek("t6_pps_after", 2'd2, 16'h0080);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
